// File: rtl/reaction_timer_core.sv
// Reaction-time sequencer: random stimulus delay, tick-based response timing,
// false-start/timeout detection, best score and block averaging.
module reaction_timer_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int SCORE_W    = 12,
  parameter int PRNG_W     = 8,
  parameter int DELAY_MIN  = 1000,
  parameter int DELAY_SPAN = 2000,
  parameter int DLY_W      = 16,
  parameter int NUM_TRIALS = 4
) (
  input  logic               clk,
  input  logic               iReset,
  input  logic [PRNG_W-1:0]  iPRNG,
  input  logic               iStart,
  input  logic               iResponse,
  input  logic               iClearBest,
  output logic               oStimulus,
  output logic               oBusy,
  output logic [SCORE_W-1:0] oScore,
  output logic               oScoreValid,
  output logic [SCORE_W-1:0] oBest,
  output logic [SCORE_W-1:0] oAverage,
  output logic               oAvgValid,
  output logic               oFalseStart,
  output logic               oTimeout,
  output logic [((NUM_TRIALS > 1) ? $clog2(NUM_TRIALS) : 1)-1:0] oTrialIdx
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PS_W   = $clog2(DIV);
  localparam int SPAN_W = $clog2(DELAY_SPAN + 1);
  localparam int PROD_W = PRNG_W + SPAN_W;
  localparam int AVG_SH = $clog2(NUM_TRIALS);
  localparam int IDX_W  = (AVG_SH < 1) ? 1 : AVG_SH;
  localparam int ACC_W  = SCORE_W + AVG_SH;
  localparam logic [SCORE_W-1:0] SMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ARMED
  } state_t;

  state_t             r_state;
  logic [PS_W-1:0]    r_ps;
  logic [DLY_W-1:0]   r_dly;
  logic [SCORE_W-1:0] r_cnt;
  logic [ACC_W-1:0]   r_acc;

  logic               w_tick;
  logic [PROD_W-1:0]  w_prod;
  logic [DLY_W-1:0]   w_delay;
  logic [ACC_W-1:0]   w_sum;
  logic               w_last;

  assign w_tick  = (r_ps == PS_W'(DIV - 1));
  assign w_prod  = PROD_W'(iPRNG) * PROD_W'(DELAY_SPAN);
  assign w_delay = DLY_W'(DELAY_MIN) + DLY_W'(w_prod >> PRNG_W);
  assign w_sum   = r_acc + ACC_W'(r_cnt);
  assign w_last  = (oTrialIdx == IDX_W'(NUM_TRIALS - 1));

  always_ff @(posedge clk) begin
    if (iReset) begin
      r_state     <= S_IDLE;
      r_ps        <= '0;
      r_dly       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      oStimulus   <= 1'b0;
      oBusy       <= 1'b0;
      oScore      <= '0;
      oScoreValid <= 1'b0;
      oBest       <= SMAX;
      oAverage    <= '0;
      oAvgValid   <= 1'b0;
      oFalseStart <= 1'b0;
      oTimeout    <= 1'b0;
      oTrialIdx   <= '0;
    end else begin
      oScoreValid <= 1'b0;
      oAvgValid   <= 1'b0;
      oFalseStart <= 1'b0;
      oTimeout    <= 1'b0;
      r_ps        <= w_tick ? '0 : r_ps + PS_W'(1);
      unique case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_state <= S_WAIT;
            r_dly   <= w_delay;
            r_ps    <= '0;
            oBusy   <= 1'b1;
          end
        end
        S_WAIT: begin
          // A press on the final tick is still a false start
          if (iResponse) begin
            r_state     <= S_IDLE;
            r_ps        <= '0;
            oBusy       <= 1'b0;
            oFalseStart <= 1'b1;
          end else if (w_tick) begin
            if (r_dly == DLY_W'(1)) begin
              r_state   <= S_ARMED;
              r_cnt     <= '0;
              r_ps      <= '0;
              oStimulus <= 1'b1;
            end else begin
              r_dly <= r_dly - DLY_W'(1);
            end
          end
        end
        S_ARMED: begin
          if (iResponse) begin
            r_state     <= S_IDLE;
            r_ps        <= '0;
            oStimulus   <= 1'b0;
            oBusy       <= 1'b0;
            oScore      <= r_cnt;
            oScoreValid <= 1'b1;
            if (r_cnt < oBest) oBest <= r_cnt;
            if (w_last) begin
              oAverage  <= SCORE_W'(w_sum >> AVG_SH);
              oAvgValid <= 1'b1;
              r_acc     <= '0;
              oTrialIdx <= '0;
            end else begin
              r_acc     <= w_sum;
              oTrialIdx <= oTrialIdx + IDX_W'(1);
            end
          end else if (w_tick) begin
            if (r_cnt == SMAX - SCORE_W'(1)) begin
              r_state   <= S_IDLE;
              r_ps      <= '0;
              oStimulus <= 1'b0;
              oBusy     <= 1'b0;
              oTimeout  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + SCORE_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Clear takes precedence over a coincident score update
      if (iClearBest) begin
        oBest     <= SMAX;
        r_acc     <= '0;
        oTrialIdx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Scenario bench for reaction_timer_core with a score scoreboard.
// Small parameters: DIV=8, delay 3..6 ticks, 6-bit scores.
module tb_reaction_timer_core;

  logic       clk = 1'b0;
  logic       iReset = 1'b1;
  logic [7:0] iPRNG = '0;
  logic       iStart = 1'b0;
  logic       iResponse = 1'b0;
  logic       iClearBest = 1'b0;
  logic       oStimulus, oBusy, oScoreValid, oAvgValid;
  logic       oFalseStart, oTimeout;
  logic [5:0] oScore, oBest, oAverage;
  logic [1:0] oTrialIdx;

  int checks = 0;
  int errors = 0;
  int q[$];

  always #5 clk = ~clk;

  reaction_timer_core #(
    .CLK_HZ(8), .TICK_HZ(1), .SCORE_W(6), .PRNG_W(8),
    .DELAY_MIN(3), .DELAY_SPAN(4), .DLY_W(16), .NUM_TRIALS(4)
  ) dut (
    .clk(clk), .iReset(iReset), .iPRNG(iPRNG),
    .iStart(iStart), .iResponse(iResponse),
    .iClearBest(iClearBest), .oStimulus(oStimulus),
    .oBusy(oBusy), .oScore(oScore),
    .oScoreValid(oScoreValid), .oBest(oBest),
    .oAverage(oAverage), .oAvgValid(oAvgValid),
    .oFalseStart(oFalseStart), .oTimeout(oTimeout),
    .oTrialIdx(oTrialIdx)
  );

  // Scoreboard: every oScoreValid must match the oldest expected score
  always @(negedge clk) begin
    if (oScoreValid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_score: got %0d, none expected", oScore);
      end else begin
        int e;
        e = q.pop_front();
        if (oScore !== 6'(e)) begin
          errors++;
          $display("FAIL score: got %0d, expected %0d", oScore, e);
        end
      end
    end
  end

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  // Start a trial, check its delay, respond after k ticks plus off cycles
  task automatic run_trial(input int prng, input int k, input int off,
                           input bit clr, input bit avg_exp,
                           input int avg_val);
    int n;
    int exp_n;
    iPRNG  = 8'(prng);
    iStart = 1'b1;
    tick_edge();
    iStart = 1'b0;
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got %b, expected 1", oBusy);
    end
    n = 0;
    while (oStimulus !== 1'b1 && n < 200) begin
      tick_edge();
      n++;
    end
    exp_n = (3 + ((prng * 4) >> 8)) * 8;
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL stim_delay: got %0d cycles, expected %0d", n, exp_n);
    end
    repeat (k * 8 + off - 1) @(posedge clk);
    #1;
    iResponse  = 1'b1;
    iClearBest = clr;
    q.push_back(k);
    tick_edge();
    iResponse  = 1'b0;
    iClearBest = 1'b0;
    checks++;
    if (oScoreValid !== 1'b1 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL score_pulse: valid=%b busy=%b, expected 1/0",
               oScoreValid, oBusy);
    end
    checks++;
    if (oAvgValid !== avg_exp) begin
      errors++;
      $display("FAIL avg_valid: got %b, expected %b", oAvgValid, avg_exp);
    end
    if (avg_exp) begin
      checks++;
      if (oAverage !== 6'(avg_val)) begin
        errors++;
        $display("FAIL average: got %0d, expected %0d", oAverage, avg_val);
      end
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    iReset = 1'b0;
    checks++;
    if (oStimulus !== 0 || oBusy !== 0 || oScore !== 0 ||
        oScoreValid !== 0 || oBest !== 6'd63 || oAverage !== 0 ||
        oAvgValid !== 0 || oFalseStart !== 0 || oTimeout !== 0 ||
        oTrialIdx !== 0) begin
      errors++;
      $display("FAIL reset_state: stim=%b busy=%b score=%0d best=%0d avg=%0d idx=%0d, expected 0 0 0 63 0 0",
               oStimulus, oBusy, oScore, oBest, oAverage, oTrialIdx);
    end
  endtask

  task automatic test_delay_score();
    run_trial(128, 2, 4, 1'b0, 1'b0, 0);
    tick_edge();
    checks++;
    if (oScoreValid !== 1'b0) begin
      errors++;
      $display("FAIL valid_width: got %b, expected 0", oScoreValid);
    end
    checks++;
    if (oBest !== 6'd2 || oTrialIdx !== 2'd1) begin
      errors++;
      $display("FAIL best_after_first: best=%0d idx=%0d, expected 2 1",
               oBest, oTrialIdx);
    end
  endtask

  task automatic test_false_start();
    iPRNG  = 8'd0;
    iStart = 1'b1;
    tick_edge();
    iStart = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    iResponse = 1'b1;
    tick_edge();
    iResponse = 1'b0;
    checks++;
    if (oFalseStart !== 1'b1 || oBusy !== 1'b0 || oStimulus !== 1'b0) begin
      errors++;
      $display("FAIL false_start: fs=%b busy=%b stim=%b, expected 1 0 0",
               oFalseStart, oBusy, oStimulus);
    end
    checks++;
    if (oBest !== 6'd2 || oTrialIdx !== 2'd1) begin
      errors++;
      $display("FAIL fs_no_update: best=%0d idx=%0d, expected 2 1",
               oBest, oTrialIdx);
    end
    tick_edge();
    checks++;
    if (oFalseStart !== 1'b0) begin
      errors++;
      $display("FAIL fs_width: got %b, expected 0", oFalseStart);
    end
  endtask

  task automatic test_timeout();
    int n;
    iPRNG  = 8'd0;
    iStart = 1'b1;
    tick_edge();
    iStart = 1'b0;
    n = 0;
    while (oStimulus !== 1'b1 && n < 200) begin
      tick_edge();
      n++;
    end
    n = 0;
    while (oTimeout !== 1'b1 && n < 700) begin
      tick_edge();
      n++;
    end
    checks++;
    if (n != 504) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d, expected 504", n);
    end
    checks++;
    if (oBusy !== 1'b0 || oStimulus !== 1'b0 || oTrialIdx !== 2'd1) begin
      errors++;
      $display("FAIL timeout_state: busy=%b stim=%b idx=%0d, expected 0 0 1",
               oBusy, oStimulus, oTrialIdx);
    end
    tick_edge();
    checks++;
    if (oTimeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: got %b, expected 0", oTimeout);
    end
  endtask

  task automatic test_average();
    iClearBest = 1'b1;
    tick_edge();
    iClearBest = 1'b0;
    checks++;
    if (oBest !== 6'd63 || oTrialIdx !== 2'd0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL idle_clear: best=%0d idx=%0d busy=%b, expected 63 0 0",
               oBest, oTrialIdx, oBusy);
    end
    run_trial(0, 5, 3, 1'b0, 1'b0, 0);
    run_trial(64, 6, 1, 1'b0, 1'b0, 0);
    checks++;
    if (oTrialIdx !== 2'd2) begin
      errors++;
      $display("FAIL idx_mid: got %0d, expected 2", oTrialIdx);
    end
    run_trial(255, 7, 7, 1'b0, 1'b0, 0);
    run_trial(200, 9, 2, 1'b0, 1'b1, 6);
    checks++;
    if (oBest !== 6'd5 || oTrialIdx !== 2'd0) begin
      errors++;
      $display("FAIL avg_block: best=%0d idx=%0d, expected 5 0",
               oBest, oTrialIdx);
    end
  endtask

  task automatic test_clear();
    run_trial(0, 3, 2, 1'b0, 1'b0, 0);
    run_trial(0, 5, 2, 1'b0, 1'b0, 0);
    run_trial(0, 4, 5, 1'b1, 1'b0, 0);
    checks++;
    if (oScore !== 6'd4 || oBest !== 6'd63 || oTrialIdx !== 2'd0) begin
      errors++;
      $display("FAIL clear_coincident: score=%0d best=%0d idx=%0d, expected 4 63 0",
               oScore, oBest, oTrialIdx);
    end
  endtask

  // Each start lands on the cycle the previous score pulse is high
  task automatic test_back_to_back();
    run_trial(30, 1, 6, 1'b0, 1'b0, 0);
    run_trial(100, 2, 3, 1'b0, 1'b0, 0);
    run_trial(190, 3, 1, 1'b0, 1'b0, 0);
    run_trial(250, 6, 7, 1'b0, 1'b1, 3);
    checks++;
    if (oBest !== 6'd1 || oTrialIdx !== 2'd0) begin
      errors++;
      $display("FAIL b2b_best: best=%0d idx=%0d, expected 1 0",
               oBest, oTrialIdx);
    end
  endtask

  task automatic test_reset_armed();
    int n;
    iPRNG  = 8'd0;
    iStart = 1'b1;
    tick_edge();
    iStart = 1'b0;
    n = 0;
    while (oStimulus !== 1'b1 && n < 200) begin
      tick_edge();
      n++;
    end
    repeat (5) tick_edge();
    iStart = 1'b1;
    tick_edge();
    iStart = 1'b0;
    checks++;
    if (oStimulus !== 1'b1 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: stim=%b busy=%b, expected 1 1",
               oStimulus, oBusy);
    end
    iReset = 1'b1;
    tick_edge();
    iReset = 1'b0;
    checks++;
    if (oStimulus !== 0 || oBusy !== 0 || oScore !== 0 ||
        oScoreValid !== 0 || oBest !== 6'd63 || oAverage !== 0 ||
        oAvgValid !== 0 || oTimeout !== 0 || oTrialIdx !== 0) begin
      errors++;
      $display("FAIL reset_armed: stim=%b busy=%b score=%0d best=%0d avg=%0d idx=%0d, expected 0 0 0 63 0 0",
               oStimulus, oBusy, oScore, oBest, oAverage, oTrialIdx);
    end
    repeat (3) tick_edge();
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL stays_idle: busy=%b, expected 0", oBusy);
    end
  endtask

  initial begin
    test_reset();
    test_delay_score();
    test_false_start();
    test_timeout();
    test_average();
    test_clear();
    test_back_to_back();
    test_reset_armed();
    tick_edge();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d scores outstanding, expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
